// File: rtl/ls_port_arbiter.sv
// Single-port local store arbiter for the LSU, instruction fetch and DMA requesters.
// LSU has fixed priority; fetch and DMA share round-robin; reads return one cycle after grant.
module ls_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         lsu_req,
    input  logic         lsu_we,
    input  logic [14:0]  lsu_addr,
    input  logic [127:0] lsu_wdata,
    output logic [127:0] lsu_rdata,
    output logic         lsu_rvalid,
    input  logic         if_req,
    input  logic [14:0]  if_addr,
    output logic         if_gnt,
    output logic [127:0] if_rdata,
    output logic         if_rvalid,
    input  logic         dma_req,
    input  logic         dma_we,
    input  logic [14:0]  dma_addr,
    input  logic [127:0] dma_wdata,
    output logic         dma_gnt,
    output logic [127:0] dma_rdata,
    output logic         dma_rvalid,
    output logic         ls_wrt_en,
    output logic [14:0]  ls_address,
    output logic [127:0] ls_data_input,
    input  logic [127:0] ls_data_output,
    output logic         lsu_block
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {RET_NONE, RET_LSU, RET_IF, RET_DMA} ret_e;

    ret_e          ret_sel, ret_nxt;
    logic          rr, rr_nxt;        // 0 = fetch wins next tie, 1 = DMA
    logic [CW-1:0] if_cnt, dma_cnt, if_cnt_nxt, dma_cnt_nxt;
    logic          blk_nxt;
    logic [14:0]   addr_sel;

    always_comb begin
        if_gnt        = 1'b0;
        dma_gnt       = 1'b0;
        rr_nxt        = rr;
        ls_wrt_en     = 1'b0;
        addr_sel      = lsu_addr;
        ls_data_input = lsu_wdata;
        ret_nxt       = RET_NONE;
        if (!reset) begin
            if (lsu_req) begin
                ls_wrt_en = lsu_we;
                ret_nxt   = lsu_we ? RET_NONE : RET_LSU;
            end else if (if_req && dma_req) begin
                if (rr) dma_gnt = 1'b1;
                else    if_gnt  = 1'b1;
                rr_nxt = ~rr;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
            if (if_gnt) begin
                addr_sel = if_addr;
                ret_nxt  = RET_IF;
            end
            if (dma_gnt) begin
                addr_sel      = dma_addr;
                ls_data_input = dma_wdata;
                ls_wrt_en     = dma_we;
                ret_nxt       = dma_we ? RET_NONE : RET_DMA;
            end
        end
    end

    // Quadword-aligned: the byte offset within a quadword never reaches the macro.
    assign ls_address = addr_sel & 15'h7FF0;

    always_comb begin
        if_cnt_nxt = if_cnt;
        if (!if_req || if_gnt || flush) if_cnt_nxt = '0;
        else if (if_cnt != LIM)         if_cnt_nxt = if_cnt + CW'(1);

        dma_cnt_nxt = dma_cnt;
        if (!dma_req || dma_gnt)  dma_cnt_nxt = '0;
        else if (dma_cnt != LIM)  dma_cnt_nxt = dma_cnt + CW'(1);

        // Counters clear on grant, so the block drops the cycle after the starved grant.
        blk_nxt = (if_cnt_nxt == LIM) || (dma_cnt_nxt == LIM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ret_sel   <= RET_NONE;
            rr        <= 1'b0;
            if_cnt    <= '0;
            dma_cnt   <= '0;
            lsu_block <= 1'b0;
        end else begin
            ret_sel   <= ret_nxt;
            rr        <= rr_nxt;
            if_cnt    <= if_cnt_nxt;
            dma_cnt   <= dma_cnt_nxt;
            lsu_block <= blk_nxt;
        end
    end

    assign lsu_rvalid = !reset && (ret_sel == RET_LSU);
    assign if_rvalid  = !reset && !flush && (ret_sel == RET_IF);
    assign dma_rvalid = !reset && (ret_sel == RET_DMA);

    assign lsu_rdata = lsu_rvalid ? ls_data_output : '0;
    assign if_rdata  = if_rvalid  ? ls_data_output : '0;
    assign dma_rdata = dma_rvalid ? ls_data_output : '0;

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed bench for ls_port_arbiter with a behavioural local store model.
module tb_ls_port_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         lsu_req = 1'b0, lsu_we = 1'b0;
    logic [14:0]  lsu_addr = '0;
    logic [127:0] lsu_wdata = '0, lsu_rdata;
    logic         lsu_rvalid;
    logic         if_req = 1'b0;
    logic [14:0]  if_addr = '0;
    logic         if_gnt, if_rvalid;
    logic [127:0] if_rdata;
    logic         dma_req = 1'b0, dma_we = 1'b0;
    logic [14:0]  dma_addr = '0;
    logic [127:0] dma_wdata = '0, dma_rdata;
    logic         dma_gnt, dma_rvalid;
    logic         ls_wrt_en;
    logic [14:0]  ls_address;
    logic [127:0] ls_data_input;
    logic [127:0] ls_data_output = '0;
    logic         lsu_block;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] AA = {16{8'hAA}};
    localparam logic [127:0] D11 = {16{8'h11}};
    localparam logic [127:0] D22 = {16{8'h22}};

    ls_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .if_rvalid(if_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .ls_wrt_en(ls_wrt_en), .ls_address(ls_address), .ls_data_input(ls_data_input),
        .ls_data_output(ls_data_output), .lsu_block(lsu_block)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] pat(int i);
        return {16'hBEEF, 112'(i)};
    endfunction

    // Local store: write at the clock edge, registered read one cycle after the address.
    logic [127:0] mem [2048];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        end else if (ls_wrt_en) begin
            mem[ls_address[14:4]] <= ls_data_input;
        end
        ls_data_output <= mem[ls_address[14:4]];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        lsu_req = 0; lsu_we = 0; if_req = 0; dma_req = 0; dma_we = 0; flush = 0;
    endtask

    initial begin
        // reset state
        tick; tick;
        #2;
        chk("rst_if_gnt", 128'(if_gnt), 0);
        chk("rst_wrt_en", 128'(ls_wrt_en), 0);
        reset = 0;
        #2;
        chk("rst_rvalids", {125'd0, lsu_rvalid, if_rvalid, dma_rvalid}, 0);
        chk("rst_rdata_or", lsu_rdata | if_rdata | dma_rdata, 0);
        chk("rst_block", 128'(lsu_block), 0);
        chk("rst_rr", 128'(dut.rr), 0);
        chk("rst_cnts", 128'({dut.if_cnt, dut.dma_cnt}), 0);

        // isolated LSU store then load
        tick;
        lsu_req = 1; lsu_we = 1; lsu_addr = 15'h0040; lsu_wdata = AA;
        #2;
        chk("st_wrt_en", 128'(ls_wrt_en), 1);
        chk("st_addr", 128'(ls_address), 128'h0040);
        chk("st_data", ls_data_input, AA);
        tick;
        lsu_we = 0; lsu_addr = 15'h004F;
        #2;
        chk("ld_addr", 128'(ls_address), 128'h0040);
        chk("ld_wrt_en", 128'(ls_wrt_en), 0);
        chk("ld_no_rvalid_after_st", 128'(lsu_rvalid), 0);
        tick;
        idle;
        #2;
        chk("ld_rvalid", 128'(lsu_rvalid), 1);
        chk("ld_rdata", lsu_rdata, AA);
        chk("ld_if_rvalid", 128'(if_rvalid), 0);

        // fetch and DMA read every cycle: IF, DMA, IF, DMA
        tick;
        if_req = 1; if_addr = 15'h0100; dma_req = 1; dma_we = 0; dma_addr = 15'h0200;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("rr_if_gnt%0d", k), 128'(if_gnt), 128'((k % 2) == 0));
            chk($sformatf("rr_dma_gnt%0d", k), 128'(dma_gnt), 128'((k % 2) == 1));
            if (k > 0) begin
                chk($sformatf("rr_if_rv%0d", k), 128'(if_rvalid), 128'((k % 2) == 1));
                chk($sformatf("rr_dma_rv%0d", k), 128'(dma_rvalid), 128'((k % 2) == 0));
                chk($sformatf("rr_rdata%0d", k), if_rdata | dma_rdata,
                    ((k % 2) == 1) ? pat(16) : pat(32));
            end
            tick;
        end
        idle;
        #2;
        chk("rr_last_dma_rv", 128'(dma_rvalid), 1);
        chk("rr_last_dma_data", dma_rdata, pat(32));
        chk("rr_last_if_rv", 128'(if_rvalid), 0);
        chk("rr_back_to_if", 128'(dut.rr), 0);

        // starvation: continuous LSU loads, fetch pending
        tick;
        lsu_req = 1; lsu_we = 0; lsu_addr = 15'h0000; if_req = 1; if_addr = 15'h0300;
        for (int d = 1; d <= 4; d++) begin
            #2;
            chk($sformatf("stv_if_gnt%0d", d), 128'(if_gnt), 0);
            chk($sformatf("stv_block%0d", d), 128'(lsu_block), 0);
            tick;
        end
        #2;
        chk("stv_block_set", 128'(lsu_block), 1);
        chk("stv_if_cnt_sat", 128'(dut.if_cnt), 4);
        chk("stv_lsu_still_served", 128'(if_gnt), 0);
        tick;
        lsu_req = 0;
        #2;
        chk("stv_free_gnt", 128'(if_gnt), 1);
        chk("stv_block_held", 128'(lsu_block), 1);
        chk("stv_lsu_rv", 128'(lsu_rvalid), 1);
        chk("stv_lsu_rdata", lsu_rdata, pat(0));
        tick;
        idle;
        #2;
        chk("stv_block_clr", 128'(lsu_block), 0);
        chk("stv_if_rv", 128'(if_rvalid), 1);
        chk("stv_if_rdata", if_rdata, pat(48));

        // flush kills the pending fetch return; a fetch granted in the flush cycle returns
        tick;
        if_req = 1; if_addr = 15'h0100;
        #2;
        chk("fl_gnt", 128'(if_gnt), 1);
        tick;
        flush = 1; if_addr = 15'h0200;
        #2;
        chk("fl_if_rv", 128'(if_rvalid), 0);
        chk("fl_if_rdata", if_rdata, 0);
        chk("fl_other_rv", 128'({lsu_rvalid, dma_rvalid}), 0);
        chk("fl_gnt_in_flush", 128'(if_gnt), 1);
        tick;
        idle;
        #2;
        chk("fl_if_cnt", 128'(dut.if_cnt), 0);
        chk("fl_new_rv", 128'(if_rvalid), 1);
        chk("fl_new_rdata", if_rdata, pat(32));

        // LSU and DMA writes collide; DMA goes next cycle, then read both back
        tick;
        lsu_req = 1; lsu_we = 1; lsu_addr = 15'h0500; lsu_wdata = D11;
        dma_req = 1; dma_we = 1; dma_addr = 15'h0600; dma_wdata = D22;
        #2;
        chk("col_wrt_en", 128'(ls_wrt_en), 1);
        chk("col_addr", 128'(ls_address), 128'h0500);
        chk("col_data", ls_data_input, D11);
        chk("col_dma_gnt", 128'(dma_gnt), 0);
        tick;
        lsu_req = 0;
        #2;
        chk("col_dma_gnt2", 128'(dma_gnt), 1);
        chk("col_wrt_en2", 128'(ls_wrt_en), 1);
        chk("col_addr2", 128'(ls_address), 128'h0600);
        chk("col_data2", ls_data_input, D22);
        tick;
        dma_we = 0;
        #2;
        chk("col_rd_gnt", 128'(dma_gnt), 1);
        tick;
        idle;
        lsu_req = 1; lsu_we = 0; lsu_addr = 15'h0508;
        #2;
        chk("col_dma_rv", 128'(dma_rvalid), 1);
        chk("col_dma_rdata", dma_rdata, D22);
        tick;
        idle;
        #2;
        chk("col_lsu_rdata", lsu_rdata, D11);

        // reset in the cycle after a fetch grant, with rr pointing at DMA
        tick;
        if_req = 1; if_addr = 15'h0100; dma_req = 1; dma_addr = 15'h0200;
        #2;
        chk("mr_tie_if", 128'(if_gnt), 1);
        tick;
        dma_req = 0;
        #2;
        chk("mr_lone_if", 128'(if_gnt), 1);
        chk("mr_rr_dma", 128'(dut.rr), 1);
        tick;
        idle;
        reset = 1;
        #2;
        chk("mr_if_rv_in_rst", 128'(if_rvalid), 0);
        tick;
        reset = 0;
        #2;
        chk("mr_rvalids", {125'd0, lsu_rvalid, if_rvalid, dma_rvalid}, 0);
        chk("mr_rdata", lsu_rdata | if_rdata | dma_rdata, 0);
        chk("mr_gnts", 128'({if_gnt, dma_gnt, ls_wrt_en, lsu_block}), 0);
        chk("mr_rr", 128'(dut.rr), 0);
        chk("mr_ret_sel", 128'(dut.ret_sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
